// File: rtl/video_pixel_output.sv
// ---------------------------------------------------------------------------
// video_pixel_output
//
// Read-side partner of the CPLD video timing/address generator. While phi2 is
// low the generator places a video address on the RAM. On the last negedge of
// that low phase this block latches the returned byte. It then turns the byte
// into two RRGGBB output half-cycles for the resistor DAC.
//
// Display modes:
//   hires=0  64-colour: byte[5:0] is shown for both half-cycles
//   hires=1  2-colour : byte[7] then byte[6] select fg/bg from the palette
//
// hsync/vsync pass through a two-stage delay, so they stay aligned with the
// colour path.
//
// Optional feature: define BORDER_EN to replace the first and last
// BORDER_FETCHES fetches of each visible line with the border palette colour.
//
// Ports:
//   master_clock  in   dot clock, every register updates on its negedge
//   reset         in   asynchronous, active-low
//   phi2          in   CPU clock (master_clock/2), low = video fetch phase
//   data[7:0]     in   RAM data bus
//   visible       in   active video flag from the timing generator
//   hsync, vsync  in   active-low syncs from the timing generator
//   hires         in   0 = 64-colour, 1 = 2-colour
//   pal_we        in   palette write strobe (one master_clock)
//   pal_sel[1:0]  in   0 = bg, 1 = fg, 2 = border, 3 = reserved (ignored)
//   pal_data[5:0] in   RRGGBB palette value
//   color[5:0]    out  registered RRGGBB to the DAC
//   hsync_out     out  hsync delayed to match color
//   vsync_out     out  vsync delayed to match color
// ---------------------------------------------------------------------------
module video_pixel_output #(
    parameter int BORDER_FETCHES  = 32,
    parameter int VISIBLE_FETCHES = 320
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       phi2,
    input  logic [7:0] data,
    input  logic       visible,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hires,
    input  logic       pal_we,
    input  logic [1:0] pal_sel,
    input  logic [5:0] pal_data,
    output logic [5:0] color,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam logic [8:0] CNT_MAX   = 9'(VISIBLE_FETCHES - 1);
    localparam logic [8:0] BORDER_LO = 9'(BORDER_FETCHES);
    localparam logic [8:0] BORDER_HI = 9'(VISIBLE_FETCHES - BORDER_FETCHES);

    logic [7:0] byte_q,   byte_d;
    logic       vis_q,    vis_d;
    logic       phase_q,  phase_d;
    logic [8:0] cnt_q,    cnt_d;
    logic [8:0] idx_q,    idx_d;     // counter value belonging to byte_q
    logic [5:0] bg_q,     bg_d;
    logic [5:0] fg_q,     fg_d;
    logic [5:0] border_q, border_d;
    logic [5:0] color_q,  color_d;
    logic       hs1_q, hs2_q, vs1_q, vs2_q;

    logic       sample;
    logic       pix_bit;
    logic [5:0] pix;

    // phi2 toggles every master_clock. A negedge that sees phi2 low is
    // therefore the last one of the fetch phase, and the next negedge sees
    // phi2 high.
    assign sample = ~phi2;

    always_comb begin
        byte_d   = byte_q;
        vis_d    = vis_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bg_d     = bg_q;
        fg_d     = fg_q;
        border_d = border_q;
        phase_d  = sample ? 1'b0 : ~phase_q;

        if (sample) begin
            byte_d = data;
            vis_d  = visible;
            if (visible) begin
                idx_d = cnt_q;
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 9'd1;
            end else if (vis_q) begin
                cnt_d = '0;              // falling edge of vis_q starts a new line
            end
        end

        if (pal_we) begin
            case (pal_sel)
                2'd0:    bg_d     = pal_data;
                2'd1:    fg_d     = pal_data;
                2'd2:    border_d = pal_data;
                default: ;               // reserved slot, write dropped
            endcase
        end

        // The palette and hires are read at output time, not at sample time.
        pix_bit = phase_q ? byte_q[6] : byte_q[7];
        pix     = hires ? (pix_bit ? fg_q : bg_q) : byte_q[5:0];
`ifdef BORDER_EN
        if (idx_q < BORDER_LO || idx_q >= BORDER_HI)
            pix = border_q;
`endif
        color_d = vis_q ? pix : 6'd0;
    end

`ifndef BORDER_EN
    // Without the border feature the border register and fetch index are kept
    // (writes still land) but never reach the display.
    logic unused_border;
    assign unused_border = ^{border_q, idx_q, BORDER_LO, BORDER_HI};
`endif

    always_ff @(negedge master_clock or negedge reset) begin
        if (!reset) begin
            byte_q   <= '0;
            vis_q    <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            bg_q     <= '0;
            fg_q     <= '0;
            border_q <= '0;
            color_q  <= '0;
            hs1_q    <= 1'b1;
            hs2_q    <= 1'b1;
            vs1_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            byte_q   <= byte_d;
            vis_q    <= vis_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bg_q     <= bg_d;
            fg_q     <= fg_d;
            border_q <= border_d;
            color_q  <= color_d;
            hs1_q    <= hsync;
            hs2_q    <= hs1_q;
            vs1_q    <= vsync;
            vs2_q    <= vs1_q;
        end
    end

    assign color     = color_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;

endmodule
